// File: rtl/led_matrix_pkg.sv
// -----------------------------------------------------------------------------
// led_matrix_pkg
// Shared constants and helpers for the LED dot-matrix scan driver.
//   DEF_*      : default geometry and timing used by led_matrix_scan
//   row_idx_w  : width of a row index for a given row count
//   frame_t    : frame buffer type at the default geometry
// -----------------------------------------------------------------------------
package led_matrix_pkg;

  localparam int DEF_ROWS         = 8;
  localparam int DEF_COLS         = 8;
  localparam int DEF_SCAN_DIV     = 48829;
  localparam int DEF_DIV_BITS     = 16;
  localparam int DEF_BLANK_CYCLES = 4;

  // Row index width; never narrower than one bit.
  function automatic int row_idx_w(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  // One frame: an array of COLS-bit rows, bit set = pixel lit.
  typedef logic [DEF_COLS-1:0] frame_t [DEF_ROWS];

endpackage

// File: rtl/led_scan_tick.sv
// -----------------------------------------------------------------------------
// led_scan_tick
// Row-period divider. Counts 0..SCAN_DIV-1 and wraps; tick is high while the
// count sits at its last value, so the row advances on the wrapping edge.
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-low reset
//   tick   out  end-of-row-period strobe
//   cnt    out  position inside the current row period
// -----------------------------------------------------------------------------
module led_scan_tick #(
  parameter int SCAN_DIV = 48829,
  parameter int DIV_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  output logic                tick,
  output logic [DIV_BITS-1:0] cnt
);

  localparam logic [DIV_BITS-1:0] LAST = DIV_BITS'(SCAN_DIV - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_BITS'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/led_matrix_scan.sv
// -----------------------------------------------------------------------------
// led_matrix_scan
// Double-buffered LED dot-matrix scan driver. User logic writes whole rows into
// the back buffer; the front buffer is scanned one row per divider period with
// the columns blanked for BLANK_CYCLES after each row change. A requested swap
// is held pending and executed only when the scan wraps from the last row to
// row 0, so a frame is never torn.
//
// Optional build macro LED_MATRIX_SCAN_BRIGHTNESS_EN adds a 4-bit bright input
// and a free-running pwm counter; lit columns are gated to pwm < bright.
//
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous active-low reset
//   wr_en         in   back-buffer write strobe
//   wr_row        in   back-buffer row address (out-of-range ignored)
//   wr_data       in   row pixel data, 1 = lit
//   swap_req      in   request a buffer swap at the next frame boundary
//   bright        in   (macro only) brightness, 0 = dark, 15 = 15/16 duty
//   swap_pending  out  swap requested but not yet executed
//   frame_start   out  one-cycle pulse when row 0 begins
//   row           out  one-hot active-low row select
//   col           out  active-high column drive
// -----------------------------------------------------------------------------
module led_matrix_scan
  import led_matrix_pkg::*;
#(
  parameter int ROWS         = DEF_ROWS,
  parameter int COLS         = DEF_COLS,
  parameter int SCAN_DIV     = DEF_SCAN_DIV,
  parameter int DIV_BITS     = DEF_DIV_BITS,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [row_idx_w(ROWS)-1:0]  wr_row,
  input  logic [COLS-1:0]             wr_data,
  input  logic                        swap_req,
`ifdef LED_MATRIX_SCAN_BRIGHTNESS_EN
  input  logic [3:0]                  bright,
`endif
  output logic                        swap_pending,
  output logic                        frame_start,
  output logic [ROWS-1:0]             row,
  output logic [COLS-1:0]             col
);

  localparam int              IW       = row_idx_w(ROWS);
  localparam logic [IW-1:0]   LAST_ROW = IW'(ROWS - 1);

  logic                tick;
  logic [DIV_BITS-1:0] cnt;

  led_scan_tick #(
    .SCAN_DIV (SCAN_DIV),
    .DIV_BITS (DIV_BITS)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .cnt   (cnt)
  );

  // fb[fsel] is the front (displayed) buffer, fb[!fsel] the back buffer.
  logic [COLS-1:0] fb [2][ROWS];
  logic            fsel;
  logic [IW-1:0]   idx;
  // run stays low until the first tick so the matrix is dark before row 0.
  logic            run;

  logic                wrap;
  logic                do_swap;
  logic                wr_ok;
  logic                run_nxt;
  logic                fsel_nxt;
  logic [IW-1:0]       idx_nxt;
  logic [DIV_BITS-1:0] cnt_nxt;
  logic                blank_nxt;
  logic [COLS-1:0]     lit;
  logic [COLS-1:0]     col_nxt;

`ifdef LED_MATRIX_SCAN_BRIGHTNESS_EN
  logic [3:0] pwm;
  logic [3:0] pwm_nxt;
`endif

  // With a power-of-two row count every address is valid.
  if ((1 << IW) == ROWS) begin : g_full_rows
    assign wr_ok = 1'b1;
  end else begin : g_part_rows
    assign wr_ok = (wr_row <= LAST_ROW);
  end

  // Only a genuine wrap from the last row is a frame boundary; the first
  // entry into row 0 after reset is not.
  assign wrap    = tick && run && (idx == LAST_ROW);
  assign do_swap = wrap && swap_pending;

  // Columns are registered, so they are computed from the state the next
  // cycle will have: its row, its front buffer and its in-period count.
  always_comb begin
    run_nxt  = run | tick;
    idx_nxt  = idx;
    fsel_nxt = fsel;
    if (tick) begin
      if (!run || idx == LAST_ROW) begin
        idx_nxt = '0;
      end else begin
        idx_nxt = idx + IW'(1);
      end
    end
    if (do_swap) begin
      fsel_nxt = ~fsel;
    end
    cnt_nxt   = tick ? '0 : cnt + DIV_BITS'(1);
    blank_nxt = (cnt_nxt < DIV_BITS'(BLANK_CYCLES));
    lit       = fb[fsel_nxt][idx_nxt];
`ifdef LED_MATRIX_SCAN_BRIGHTNESS_EN
    pwm_nxt = pwm + 4'd1;
    if (pwm_nxt >= bright) begin
      lit = '0;
    end
`endif
    col_nxt = (run_nxt && !blank_nxt) ? lit : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run          <= 1'b0;
      idx          <= '0;
      fsel         <= 1'b0;
      swap_pending <= 1'b0;
      frame_start  <= 1'b0;
      row          <= '1;
      col          <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < ROWS; r++) begin
          fb[b][r] <= '0;
        end
      end
`ifdef LED_MATRIX_SCAN_BRIGHTNESS_EN
      pwm          <= '0;
`endif
    end else begin
      run          <= run_nxt;
      idx          <= idx_nxt;
      fsel         <= fsel_nxt;
      // A request arriving on the swap edge starts a fresh pending swap.
      swap_pending <= (swap_pending & ~do_swap) | swap_req;
      frame_start  <= tick && (idx_nxt == '0);
      if (tick) begin
        row <= ~(ROWS'(1) << idx_nxt);
      end
      col <= col_nxt;
      // Old fsel: a write on the swap edge lands in the buffer becoming front.
      if (wr_en && wr_ok) begin
        fb[!fsel][wr_row] <= wr_data;
      end
`ifdef LED_MATRIX_SCAN_BRIGHTNESS_EN
      pwm          <= pwm_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_led_matrix_scan.sv
// -----------------------------------------------------------------------------
// tb_led_matrix_scan
// Self-checking bench for led_matrix_scan at ROWS=4, COLS=4, SCAN_DIV=8,
// BLANK_CYCLES=2. Expected per-cycle row/col/frame_start/swap_pending values
// for a frame are queued up front and popped against the DUT each cycle.
// Build with LED_MATRIX_SCAN_BRIGHTNESS_EN to include the brightness test.
// -----------------------------------------------------------------------------
module tb_led_matrix_scan;

  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int SCAN_DIV = 8;
  localparam int DIV_BITS = 4;
  localparam int BLANK    = 2;

  logic       clk      = 1'b0;
  logic       reset    = 1'b0;
  logic       wr_en    = 1'b0;
  logic [1:0] wr_row   = '0;
  logic [3:0] wr_data  = '0;
  logic       swap_req = 1'b0;
  logic       swap_pending;
  logic       frame_start;
  logic [3:0] row;
  logic [3:0] col;

`ifdef LED_MATRIX_SCAN_BRIGHTNESS_EN
  logic [3:0] bright = 4'd15;
  logic [3:0] pwm_m;
  always @(posedge clk or negedge reset) begin
    if (!reset) pwm_m <= 4'd0;
    else        pwm_m <= pwm_m + 4'd1;
  end
`endif

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0] row;
    logic [3:0] col;
    logic       fs;
    logic       pend;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  led_matrix_scan #(
    .ROWS         (ROWS),
    .COLS         (COLS),
    .SCAN_DIV     (SCAN_DIV),
    .DIV_BITS     (DIV_BITS),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_row       (wr_row),
    .wr_data      (wr_data),
    .swap_req     (swap_req),
`ifdef LED_MATRIX_SCAN_BRIGHTNESS_EN
    .bright       (bright),
`endif
    .swap_pending (swap_pending),
    .frame_start  (frame_start),
    .row          (row),
    .col          (col)
  );

  // Column value as seen on the pins for lit data in the current cycle.
  function automatic logic [3:0] shown(input logic [3:0] d);
`ifdef LED_MATRIX_SCAN_BRIGHTNESS_EN
    return (pwm_m < bright) ? d : 4'd0;
`else
    return d;
`endif
  endfunction

  // Returns at the negedge where frame_start is high.
  task automatic wait_frame();
    int n = 0;
    @(negedge clk);
    while (frame_start !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL frame_timeout: frame_start=%b, required 1 within 100 cycles", frame_start);
    end
  endtask

  // Called on the frame_start cycle; checks all 32 cycles of the frame and
  // returns on the negedge of its last cycle.
  task automatic check_frame(input logic [3:0] d0, input logic [3:0] d1,
                             input logic [3:0] d2, input logic [3:0] d3,
                             input logic pend, input string name);
    logic [3:0] d[4];
    exp_t e;
    d = '{d0, d1, d2, d3};
    for (int r = 0; r < ROWS; r++) begin
      for (int k = 0; k < SCAN_DIV; k++) begin
        e.row  = ~(4'b0001 << r);
        e.col  = (k < BLANK) ? 4'd0 : d[r];
        e.fs   = (r == 0 && k == 0);
        e.pend = pend;
        sb.push_back(e);
      end
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (row !== e.row || col !== shown(e.col) || frame_start !== e.fs ||
          swap_pending !== e.pend) begin
        errors++;
        $display("FAIL %s: row=%b col=%h fs=%b pend=%b, required row=%b col=%h fs=%b pend=%b",
                 name, row, col, frame_start, swap_pending,
                 e.row, shown(e.col), e.fs, e.pend);
      end
      if (sb.size() > 0) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (row !== 4'hF || col !== 4'h0 || swap_pending !== 1'b0 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: row=%b col=%h pend=%b fs=%b, required 1111 0 0 0",
               row, col, swap_pending, frame_start);
    end
    reset = 1'b1;
    for (int i = 1; i < SCAN_DIV; i++) begin
      @(negedge clk);
      checks++;
      if (row !== 4'hF || col !== 4'h0 || frame_start !== 1'b0) begin
        errors++;
        $display("FAIL pre_tick[%0d]: row=%b col=%h fs=%b, required 1111 0 0",
                 i, row, col, frame_start);
      end
    end
    @(negedge clk);
    checks++;
    if (row !== 4'b1110 || col !== 4'h0 || frame_start !== 1'b1) begin
      errors++;
      $display("FAIL first_tick: row=%b col=%h fs=%b, required 1110 0 1", row, col, frame_start);
    end
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b0) begin
      errors++;
      $display("FAIL fs_pulse: fs=%b, required 0", frame_start);
    end
  endtask

  task automatic test_write_no_swap();
    for (int i = 0; i < ROWS; i++) begin
      wr_en   = 1'b1;
      wr_row  = 2'(i);
      wr_data = 4'(1 << i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    wait_frame();
    check_frame(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, "no_swap_frame");
  endtask

  task automatic test_swap();
    wait_frame();
    @(negedge clk);
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    checks++;
    if (swap_pending !== 1'b1) begin
      errors++;
      $display("FAIL pend_set: pend=%b, required 1", swap_pending);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (swap_pending !== 1'b1 || col !== 4'h0) begin
      errors++;
      $display("FAIL pend_hold: pend=%b col=%h, required 1 0", swap_pending, col);
    end
    wait_frame();
    check_frame(4'h1, 4'h2, 4'h4, 4'h8, 1'b0, "swapped_frame");
  endtask

  task automatic test_swap_on_boundary();
    wait_frame();
    for (int i = 0; i < ROWS; i++) begin
      wr_en   = 1'b1;
      wr_row  = 2'(i);
      wr_data = 4'(8 >> i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    repeat (27) @(negedge clk);
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    check_frame(4'h1, 4'h2, 4'h4, 4'h8, 1'b1, "late_req_frame");
    wait_frame();
    check_frame(4'h8, 4'h4, 4'h2, 4'h1, 1'b0, "late_swap_frame");
  endtask

  task automatic test_write_on_swap();
    wait_frame();
    @(negedge clk);
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    repeat (29) @(negedge clk);
    wr_en   = 1'b1;
    wr_row  = 2'd2;
    wr_data = 4'hF;
    @(negedge clk);
    wr_en = 1'b0;
    check_frame(4'h1, 4'h2, 4'hF, 4'h8, 1'b0, "swap_edge_write");
  endtask

  task automatic test_reset_mid();
    wait_frame();
    repeat (18) @(negedge clk);
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    @(negedge clk);
    checks++;
    if (row !== 4'b1011 || col !== shown(4'hF) || swap_pending !== 1'b1) begin
      errors++;
      $display("FAIL mid_row2: row=%b col=%h pend=%b, required 1011 %h 1",
               row, col, swap_pending, shown(4'hF));
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (row !== 4'hF || col !== 4'h0 || swap_pending !== 1'b0 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: row=%b col=%h pend=%b fs=%b, required 1111 0 0 0",
               row, col, swap_pending, frame_start);
    end
    repeat (2) @(negedge clk);
    reset   = 1'b1;
    wr_en   = 1'b1;
    wr_row  = 2'd0;
    wr_data = 4'hF;
    @(negedge clk);
    wr_en    = 1'b0;
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    wait_frame();
    check_frame(4'h0, 4'h0, 4'h0, 4'h0, 1'b1, "post_reset_frame");
    wait_frame();
    check_frame(4'hF, 4'h0, 4'h0, 4'h0, 1'b0, "post_reset_swap");
  endtask

`ifdef LED_MATRIX_SCAN_BRIGHTNESS_EN
  task automatic test_brightness();
    int lit_n = 0;
    bright = 4'd4;
    wait_frame();
    check_frame(4'hF, 4'h0, 4'h0, 4'h0, 1'b0, "bright4_frame");
    bright = 4'd0;
    wait_frame();
    for (int i = 0; i < 32; i++) begin
      if (col !== 4'h0) lit_n++;
      @(negedge clk);
    end
    checks++;
    if (lit_n !== 0) begin
      errors++;
      $display("FAIL bright0_dark: lit cycles=%0d, required 0", lit_n);
    end
    bright = 4'd15;
  endtask
`endif

  initial begin
    test_reset();
    test_write_no_swap();
    test_swap();
    test_swap_on_boundary();
    test_write_on_swap();
    test_reset_mid();
`ifdef LED_MATRIX_SCAN_BRIGHTNESS_EN
    test_brightness();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
